// File: rtl/input_cond_pkg.sv
// Shared types and default timing for the game-input front end.
package input_cond_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      REPEAT  = 2'd2
   } ch_state_e;

   localparam int CH_START  = 0;
   localparam int CH_LEFT   = 1;
   localparam int CH_RIGHT  = 2;
   localparam int CH_ROTATE = 3;
   localparam int CH_DROP   = 4;

   localparam int         DEF_NUM_CH          = 5;
   localparam int         DEF_DEBOUNCE_CYCLES = 4;
   localparam int         DEF_REPEAT_DELAY    = 20;
   localparam int         DEF_REPEAT_PERIOD   = 8;
   localparam logic [4:0] DEF_REPEAT_MASK     = 5'b00110;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/input_channel_debounce.sv
// One button channel: two-flop synchroniser, debounce counter and
// press/auto-repeat pulse FSM.
module input_channel_debounce
   import input_cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter bit REPEAT_EN       = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic pulse_o,
   output logic held_o
);

   localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RCNT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

   localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
   localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

   logic              sync1_q, sync2_q;
   logic              held_q, held_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   ch_state_e         state_q, state_d;
   logic [RCNT_W-1:0] rcnt_q, rcnt_d;
   logic              pulse_q, pulse_d;
   logic              rise, fall;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         held_q  <= 1'b0;
         cnt_q   <= '0;
         state_q <= IDLE;
         rcnt_q  <= '0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         held_q  <= held_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
         pulse_q <= pulse_d;
      end
   end

   // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
   always_comb begin
      held_d = held_q;
      cnt_d  = cnt_q;
      rise   = 1'b0;
      fall   = 1'b0;
      if (sync2_q == held_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         held_d = sync2_q;
         cnt_d  = '0;
         rise   = sync2_q;
         fall   = ~sync2_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      pulse_d = 1'b0;
      if (fall) begin
         // A release wins over a repeat pulse due on the same edge.
         state_d = IDLE;
         rcnt_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rise) begin
                  state_d = PRESSED;
                  rcnt_d  = '0;
                  pulse_d = 1'b1;
               end
            end
            PRESSED: begin
               if (REPEAT_EN) begin
                  if (rcnt_q == DELAY_LAST) begin
                     state_d = REPEAT;
                     rcnt_d  = '0;
                     pulse_d = 1'b1;
                  end else begin
                     rcnt_d = rcnt_q + 1'b1;
                  end
               end
            end
            REPEAT: begin
               if (rcnt_q == PERIOD_LAST) begin
                  rcnt_d  = '0;
                  pulse_d = 1'b1;
               end else begin
                  rcnt_d = rcnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               rcnt_d  = '0;
            end
         endcase
      end
   end

   assign pulse_o = pulse_q;
   assign held_o  = held_q;

endmodule

// File: rtl/input_pulse_conditioner.sv
// N-channel button conditioner plus arduinoClock rising-edge strobe,
// all in the system clock domain.
module input_pulse_conditioner
   import input_cond_pkg::*;
#(
   parameter int                NUM_CH          = DEF_NUM_CH,
   parameter int                DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int                REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int                REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter logic [NUM_CH-1:0] REPEAT_MASK     = DEF_REPEAT_MASK
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              arduinoClock,
   input  logic [NUM_CH-1:0] btn_raw,
   output logic [NUM_CH-1:0] btn_pulse,
   output logic [NUM_CH-1:0] btn_held,
   output logic              ard_strobe
);

   logic ard1_q, ard2_q, ard3_q, strobe_q;

   // ard1/ard2 synchronise; ard3 is the delayed copy for edge detection.
   always_ff @(posedge clock) begin
      if (reset) begin
         ard1_q   <= 1'b0;
         ard2_q   <= 1'b0;
         ard3_q   <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         ard1_q   <= arduinoClock;
         ard2_q   <= ard1_q;
         ard3_q   <= ard2_q;
         strobe_q <= ard2_q & ~ard3_q;
      end
   end

   assign ard_strobe = strobe_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      input_channel_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD),
         .REPEAT_EN       (REPEAT_MASK[i])
      ) u_ch (
         .clk_i   (clock),
         .rst_i   (reset),
         .raw_i   (btn_raw[i]),
         .pulse_o (btn_pulse[i]),
         .held_o  (btn_held[i])
      );
   end

endmodule

// File: tb/tb_input_pulse_conditioner.sv
// Directed bench: expected pulses/strobes are queued with their due cycle
// and compared against the DUT on every clock.
module tb_input_pulse_conditioner;

   localparam int NCH = 5;

   logic           clock;
   logic           reset;
   logic           arduinoClock;
   logic [NCH-1:0] btn_raw;
   logic [NCH-1:0] btn_pulse;
   logic [NCH-1:0] btn_held;
   logic           ard_strobe;

   input_pulse_conditioner dut (
      .clock        (clock),
      .reset        (reset),
      .arduinoClock (arduinoClock),
      .btn_raw      (btn_raw),
      .btn_pulse    (btn_pulse),
      .btn_held     (btn_held),
      .ard_strobe   (ard_strobe)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      int             cyc;
      logic [NCH-1:0] pulse;
      logic           strobe;
   } exp_t;

   exp_t sb[$];
   int   cyc  = 0;
   int   vecs = 0;
   int   errs = 0;
   int   c, t0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      vecs++;
      assert (obs === expv)
      else begin
         errs++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
      end
   endtask

   task automatic push(input int when, input logic [NCH-1:0] p, input logic s);
      exp_t e;
      e.cyc    = when;
      e.pulse  = p;
      e.strobe = s;
      sb.push_back(e);
   endtask

   task automatic tick();
      logic [NCH-1:0] ep;
      logic           es;
      @(posedge clock);
      #1;
      cyc++;
      ep = '0;
      es = 1'b0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            ep |= sb[i].pulse;
            es |= sb[i].strobe;
            sb.delete(i);
         end
      end
      chk("pulse", 8'(btn_pulse), 8'(ep));
      chk("strobe", 8'(ard_strobe), 8'(es));
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      reset        = 1'b1;
      arduinoClock = 1'b0;
      btn_raw      = '0;
      run(3);
      chk("rst_held", 8'(btn_held), 8'h00);
      reset = 1'b0;
      run(3);

      // ch0 press, 50-cycle hold, release; no repeat on ch0
      c = cyc;
      btn_raw[0] = 1'b1;
      push(c + 6, 5'b00001, 1'b0);
      run(5);
      chk("held0_pre", 8'(btn_held[0]), 8'h00);
      run(1);
      chk("held0_rise", 8'(btn_held[0]), 8'h01);
      run(44);
      btn_raw[0] = 1'b0;
      run(5);
      chk("held0_still", 8'(btn_held[0]), 8'h01);
      run(1);
      chk("held0_fall", 8'(btn_held[0]), 8'h00);
      run(6);

      // 3-cycle glitch rejected, 6-cycle press accepted once
      btn_raw[1] = 1'b1;
      run(3);
      btn_raw[1] = 1'b0;
      run(8);
      chk("glitch_held1", 8'(btn_held[1]), 8'h00);
      c = cyc;
      btn_raw[1] = 1'b1;
      push(c + 6, 5'b00010, 1'b0);
      run(6);
      chk("short_held1", 8'(btn_held[1]), 8'h01);
      btn_raw[1] = 1'b0;
      run(6);
      chk("short_rel1", 8'(btn_held[1]), 8'h00);
      run(20);

      // ch1 auto-repeat; release lands on the edge of the t0+52 repeat
      c  = cyc;
      t0 = c + 6;
      btn_raw[1] = 1'b1;
      push(t0,      5'b00010, 1'b0);
      push(t0 + 20, 5'b00010, 1'b0);
      push(t0 + 28, 5'b00010, 1'b0);
      push(t0 + 36, 5'b00010, 1'b0);
      push(t0 + 44, 5'b00010, 1'b0);
      run(52);
      btn_raw[1] = 1'b0;
      run(5);
      chk("rep_held1", 8'(btn_held[1]), 8'h01);
      run(1);
      chk("rep_rel1", 8'(btn_held[1]), 8'h00);
      run(10);

      // ch0 and ch2 together: both pulse at once, only ch2 repeats
      c = cyc;
      btn_raw = 5'b00101;
      push(c + 6,  5'b00101, 1'b0);
      push(c + 26, 5'b00100, 1'b0);
      push(c + 34, 5'b00100, 1'b0);
      run(35);
      btn_raw = '0;
      run(5);
      chk("sim_held", 8'(btn_held), 8'h05);
      run(1);
      chk("sim_rel", 8'(btn_held), 8'h00);
      run(10);

      // reset while ch1 is repeating, button stays down through it
      c = cyc;
      btn_raw[1] = 1'b1;
      push(c + 6,  5'b00010, 1'b0);
      push(c + 26, 5'b00010, 1'b0);
      run(30);
      chk("mid_held1", 8'(btn_held[1]), 8'h01);
      reset = 1'b1;
      run(2);
      chk("mid_rst_held", 8'(btn_held), 8'h00);
      reset = 1'b0;
      push(c + 38, 5'b00010, 1'b0);
      push(c + 58, 5'b00010, 1'b0);
      run(5);
      chk("post_rst_pre", 8'(btn_held[1]), 8'h00);
      run(1);
      chk("post_rst_rise", 8'(btn_held[1]), 8'h01);
      run(21);
      btn_raw[1] = 1'b0;
      run(6);
      chk("post_rst_rel", 8'(btn_held[1]), 8'h00);
      run(10);

      // arduinoClock with period 10: strobe 3 edges after each rise only
      for (int k = 0; k < 4; k++) begin
         c = cyc;
         arduinoClock = 1'b1;
         push(c + 3, 5'b00000, 1'b1);
         run(5);
         arduinoClock = 1'b0;
         run(5);
      end
      run(5);

      chk("sb_empty", 8'(sb.size()), 8'h00);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
